// File: rtl/step_counter.sv
// Registered up/down counter with configurable width and step, wrap or
// saturate on crossing a bound, synchronous load, and overflow/zero flags.
module step_counter #(
    parameter int WIDTH     = 2,
    parameter int STEP      = 1,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             en,
    input  logic             up,
    input  logic             sat,
    output logic [WIDTH-1:0] q,
    output logic             ovf,
    output logic             zero
);

    localparam logic [WIDTH:0]   STEP_EXT = (WIDTH + 1)'(STEP);
    localparam logic [WIDTH-1:0] RESET_Q  = WIDTH'(RESET_VAL);

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] q_next;
    logic             ovf_next;

    // Bit WIDTH of the extended sum is the carry (up) or borrow (down).
    always_comb begin
        sum = up ? ({1'b0, q} + STEP_EXT) : ({1'b0, q} - STEP_EXT);
    end

    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latches.
        q_next   = q;
        ovf_next = 1'b0;
        if (load) begin
            q_next = d;
        end else if (en) begin
            ovf_next = sum[WIDTH];
            if (sat && sum[WIDTH]) begin
                q_next = up ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
            end else begin
                q_next = sum[WIDTH-1:0];
            end
        end
    end

    // NOTE: non-blocking assignments for all state so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            q    <= RESET_Q;
            ovf  <= 1'b0;
            zero <= (RESET_Q == '0);
        end else begin
            q    <= q_next;
            ovf  <= ovf_next;
            zero <= (q_next == '0);
        end
    end

endmodule

// File: tb/tb_step_counter.sv
// Directed test of step_counter: a 2-bit legacy-compatible instance and an
// 8-bit step-3 instance with a non-zero reset value.
module tb_step_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // 2-bit, step 1, reset 0
    logic       rst_a, load_a, en_a, up_a, sat_a;
    logic [1:0] d_a, q_a;
    logic       ovf_a, zero_a;

    // 8-bit, step 3, reset 4
    logic       rst_b, load_b, en_b, up_b, sat_b;
    logic [7:0] d_b, q_b;
    logic       ovf_b, zero_b;

    step_counter #(.WIDTH(2), .STEP(1), .RESET_VAL(0)) u_dut_a (
        .clk(clk), .rst(rst_a), .load(load_a), .d(d_a), .en(en_a),
        .up(up_a), .sat(sat_a), .q(q_a), .ovf(ovf_a), .zero(zero_a)
    );

    step_counter #(.WIDTH(8), .STEP(3), .RESET_VAL(4)) u_dut_b (
        .clk(clk), .rst(rst_b), .load(load_b), .d(d_b), .en(en_b),
        .up(up_b), .sat(sat_b), .q(q_b), .ovf(ovf_b), .zero(zero_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ctl_a(input logic r, input logic l, input logic [1:0] dv,
                         input logic e, input logic u, input logic s);
        rst_a = r; load_a = l; d_a = dv; en_a = e; up_a = u; sat_a = s;
    endtask

    task automatic ctl_b(input logic r, input logic l, input logic [7:0] dv,
                         input logic e, input logic u, input logic s);
        rst_b = r; load_b = l; d_b = dv; en_b = e; up_b = u; sat_b = s;
    endtask

    task automatic chk_a(input string tag, input logic [1:0] eq, input logic eo, input logic ez);
        check({tag, ".q"}, 32'(q_a), 32'(eq));
        check({tag, ".ovf"}, 32'(ovf_a), 32'(eo));
        check({tag, ".zero"}, 32'(zero_a), 32'(ez));
    endtask

    task automatic chk_b(input string tag, input logic [7:0] eq, input logic eo, input logic ez);
        check({tag, ".q"}, 32'(q_b), 32'(eq));
        check({tag, ".ovf"}, 32'(ovf_b), 32'(eo));
        check({tag, ".zero"}, 32'(zero_b), 32'(ez));
    endtask

    initial begin
        logic [1:0] down_seq [4];
        logic [1:0] legacy;
        down_seq = '{2'd3, 2'd2, 2'd1, 2'd0};

        ctl_a(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        ctl_b(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
        tick();
        chk_a("a_reset", 2'd0, 1'b0, 1'b1);
        chk_b("b_reset", 8'd4, 1'b0, 1'b0);

        // Legacy decrement from 0: wraps once, then counts down to 0.
        ctl_a(1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_a($sformatf("a_down%0d", i), down_seq[i], (i == 0), (down_seq[i] == 2'd0));
        end

        ctl_a(1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
        tick();
        chk_a("a_load2", 2'b10, 1'b0, 1'b0);
        ctl_a(1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
        tick();
        chk_a("a_dec2", 2'b01, 1'b0, 1'b0);

        // Every input of the legacy dut: out = in - 1 mod 4.
        for (int i = 0; i < 4; i++) begin
            legacy = 2'((i + 3) % 4);
            ctl_a(1'b0, 1'b1, 2'(i), 1'b0, 1'b0, 1'b0);
            tick();
            ctl_a(1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
            tick();
            chk_a($sformatf("a_legacy%0d", i), legacy, (i == 0), (legacy == 2'd0));
        end

        // Wrap up through 255.
        ctl_b(1'b0, 1'b1, 8'd254, 1'b0, 1'b0, 1'b0);
        tick();
        ctl_b(1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0);
        tick();
        chk_b("b_wrap_up", 8'd1, 1'b1, 1'b0);
        ctl_b(1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
        tick();
        chk_b("b_hold", 8'd1, 1'b0, 1'b0);

        // Saturate at top, then stay there with ovf repeating.
        ctl_b(1'b0, 1'b1, 8'd254, 1'b0, 1'b0, 1'b0);
        tick();
        ctl_b(1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b1);
        tick();
        chk_b("b_sat_up", 8'd255, 1'b1, 1'b0);
        tick();
        chk_b("b_sat_up_again", 8'd255, 1'b1, 1'b0);

        // Saturate at bottom, then reverse direction.
        ctl_b(1'b0, 1'b1, 8'd2, 1'b0, 1'b0, 1'b0);
        tick();
        ctl_b(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1);
        tick();
        chk_b("b_sat_dn", 8'd0, 1'b1, 1'b1);
        tick();
        chk_b("b_sat_dn_again", 8'd0, 1'b1, 1'b1);
        ctl_b(1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b1);
        tick();
        chk_b("b_sat_reverse", 8'd3, 1'b0, 1'b0);

        // Priority: load over en, rst over load.
        ctl_b(1'b0, 1'b1, 8'd5, 1'b1, 1'b1, 1'b0);
        tick();
        chk_b("b_load_wins", 8'd5, 1'b0, 1'b0);
        ctl_b(1'b1, 1'b1, 8'd7, 1'b1, 1'b1, 1'b0);
        tick();
        chk_b("b_rst_wins", 8'd4, 1'b0, 1'b0);

        // Reset mid-count, then resume from the reset value.
        ctl_b(1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0);
        tick();
        chk_b("b_load0", 8'd0, 1'b0, 1'b1);
        ctl_b(1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0);
        tick();
        chk_b("b_cnt3", 8'd3, 1'b0, 1'b0);
        tick();
        chk_b("b_cnt6", 8'd6, 1'b0, 1'b0);
        ctl_b(1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0);
        tick();
        chk_b("b_mid_rst", 8'd4, 1'b0, 1'b0);
        ctl_b(1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0);
        tick();
        chk_b("b_resume", 8'd7, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
